// File: rtl/add_seq_ctrl.sv
// Sequential multi-segment adder/subtractor.
// A single 16-bit carry-select adder is reused over NSEG cycles, LSB segment first.

// 16-bit carry-select adder: ripple low byte, precompute high byte for both carries.
module CSA_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_cout
);
   logic [8:0] w_lo;
   logic [8:0] w_hi0;
   logic [8:0] w_hi1;

   // Low half plus two speculative high halves, selected by the low-half carry.
   always_comb begin
      w_lo   = {1'b0, i_a[7:0]} + {1'b0, i_b[7:0]} + {8'b0, i_cin};
      w_hi0  = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]};
      w_hi1  = {1'b0, i_a[15:8]} + {1'b0, i_b[15:8]} + 9'd1;
      o_sum  = w_lo[8] ? {w_hi1[7:0], w_lo[7:0]} : {w_hi0[7:0], w_lo[7:0]};
      o_cout = w_lo[8] ? w_hi1[8] : w_hi0[8];
   end
endmodule

module add_seq_ctrl #(
   parameter int NSEG = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [16*NSEG-1:0]   op_a,
   input  logic [16*NSEG-1:0]   op_b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [16*NSEG-1:0]   result,
   output logic                 cout,
   output logic                 overflow,
   output logic                 busy
);
   localparam int W  = 16 * NSEG;
   localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_carry;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_result;
   logic            r_cout;
   logic            r_ovf;

   logic [15:0]     w_seg_a;
   logic [15:0]     w_seg_b;
   logic [15:0]     w_sum;
   logic            w_cout;
   logic            w_last;

   assign w_seg_a = r_a[{r_cnt, 4'b0000} +: 16];
   assign w_seg_b = r_b[{r_cnt, 4'b0000} +: 16];
   assign w_last  = (r_cnt == LAST);

   CSA_16bit u_csa (
      .i_a    (w_seg_a),
      .i_b    (w_seg_b),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operand capture on accept, then one segment per cycle through the CSA.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= op_a;
                  r_b     <= sub ? ~op_b : op_b;
                  r_carry <= sub;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_result[{r_cnt, 4'b0000} +: 16] <= w_sum;
               r_carry <= w_cout;
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sum[15] != r_a[W-1]);
                  r_cnt  <= '0;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign cout     = r_cout;
   assign overflow = r_ovf;
endmodule
